alu_cmd_seq: RTL and testbench
==============================

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand/result width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  command offered.
REQ-006 SHALL have port in_ready  output  1  command FIFO can accept.
REQ-007 SHALL have ports in_oc  input  3, in_a  input  DATA_WIDTH, in_b  input  DATA_WIDTH  command opcode/operands.
REQ-008 SHALL have ports alu_oc  output  3, alu_a  output  DATA_WIDTH, alu_b  output  DATA_WIDTH  registered drive to the combinational ALU.
REQ-009 SHALL have port alu_f  input  DATA_WIDTH  ALU result.
REQ-010 SHALL have ports out_valid  output  1, out_ready  input  1  result handshake.
REQ-011 SHALL have ports out_f  output  DATA_WIDTH, out_oc  output  3, out_err  output  1  result, its opcode, divide-by-zero flag.
REQ-012 SHALL have port done_cnt  output  16  completed-result counter.

Function
REQ-013 SHALL accept a command on any rising edge with in_valid && in_ready; in_ready = FIFO not full (independent of same-cycle pop).
REQ-014 SHALL store commands in FIFO order; read/write pointers wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
REQ-015 SHALL implement FSM states IDLE, EXEC, HOLD.
REQ-016 IDLE: if FIFO non-empty, pop head into alu_oc/alu_a/alu_b, go EXEC; else stay.
REQ-017 EXEC (exactly one cycle): register alu_f into out_f, alu_oc into out_oc, set out_valid, go HOLD.
REQ-018 In EXEC, if alu_oc == 3'b011 and alu_b == 0: out_f = 0, out_err = 1 (ALU output ignored); otherwise out_err = 0.
REQ-019 HOLD: out_f/out_oc/out_err/out_valid stable until out_valid && out_ready.
REQ-020 HOLD with out_ready: clear out_valid, increment done_cnt (wraps 16'hFFFF -> 0); if FIFO non-empty pop next into ALU regs and go EXEC same edge, else go IDLE.
REQ-021 Latency: command accepted at edge T into empty FIFO while IDLE -> out_valid high after edge T+2.
REQ-022 Throughput: at most one result per two cycles under continuous out_ready.
REQ-023 Push and pop on same edge SHALL both take effect; occupancy unchanged.
REQ-024 in_valid while full: command not accepted, FIFO unchanged.
REQ-025 alu_oc/alu_a/alu_b SHALL only change on a pop; held otherwise.
REQ-026 Arithmetic is performed solely by the external ALU; results truncated to DATA_WIDTH as produced.

Reset
REQ-027 rst high SHALL immediately (asynchronously) force: state IDLE, pointers/occupancy 0, in_ready 1 after release, out_valid 0, out_f 0, out_oc 0, out_err 0, alu_oc/alu_a/alu_b 0, done_cnt 0.
REQ-028 Reset mid-operation SHALL discard all queued and in-flight commands; no result emitted for them.

Structure
REQ-029 Shared package alu_seq_pkg SHALL hold opcode constants (OC_ADD=000, OC_SUB=001, OC_MUL=010, OC_DIV=011, OC_NOT=100, OC_XOR=101, OC_OR=110, OC_AND=111) and the FSM state encoding.
REQ-030 Command storage SHALL be one sub-module cmd_fifo (synchronous FIFO, width 3+2*DATA_WIDTH, same clk/rst).

Verification
REQ-031 Single ADD: in 000/a=5/b=7, out_ready=1 -> out_valid after edge T+2, out_f=12, out_err=0, done_cnt=1.
REQ-032 Divide by zero: in 011/a=9/b=0 -> out_f=0, out_err=1; then 011/a=9/b=3 -> out_f=3, out_err=0.
REQ-033 Backpressure: out_ready=0, push 5 commands -> 4 accepted, in_ready=0 on 5th; raise out_ready -> 4 results in push order, then in_ready=1.
REQ-034 Result hold: out_ready=0 for 10 cycles on SUB 10-3 -> out_f=7 stable, out_valid stays 1, done_cnt unchanged until handshake.
REQ-035 Reset mid-operation: 3 queued, rst pulsed during EXEC -> all outputs 0, no further out_valid, next command processes normally.
REQ-036 Wrap: 6 back-to-back commands (MUL 3*4, NOT 0, XOR F0F0^0FF0, OR, AND, ADD FFFF+1) -> 12, FFFF, FF00, correct OR/AND, 0000 in order; pointer wrap exercised.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode constants and sequencer state encoding for the ALU command sequencer.
package alu_seq_pkg;

  localparam logic [2:0] OC_ADD = 3'b000;
  localparam logic [2:0] OC_SUB = 3'b001;
  localparam logic [2:0] OC_MUL = 3'b010;
  localparam logic [2:0] OC_DIV = 3'b011;
  localparam logic [2:0] OC_NOT = 3'b100;
  localparam logic [2:0] OC_XOR = 3'b101;
  localparam logic [2:0] OC_OR  = 3'b110;
  localparam logic [2:0] OC_AND = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with occupancy counter; pushes while full and pops while empty are ignored.
module cmd_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_cmd_seq.sv
// Queues ALU commands, drives an external combinational ALU one command at a time,
// and presents each result on a valid/ready handshake.
module alu_cmd_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_oc,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic [2:0]            alu_oc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_f,
  output logic [2:0]            out_oc,
  output logic                  out_err,
  output logic [15:0]           done_cnt
);

  localparam int CMD_W = 3 + 2 * DATA_WIDTH;

  function automatic logic div_by_zero(input logic [2:0] oc, input logic [DATA_WIDTH-1:0] b);
    return (oc == OC_DIV) && (b == '0);
  endfunction

  state_t            state;
  state_t            state_next;
  logic              pop;
  logic              load_out;
  logic              done_inc;
  logic              full;
  logic              empty;
  logic [CMD_W-1:0]  head;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   ({in_oc, in_a, in_b}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign in_ready  = !full;
  assign out_valid = (state == ST_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_out   = 1'b0;
    done_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        load_out   = 1'b1;
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          done_inc = 1'b1;
          if (!empty) begin
            pop        = 1'b1;
            state_next = ST_EXEC;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ALU drive changes only on a pop; result registers load only in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_oc   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      out_f    <= '0;
      out_oc   <= '0;
      out_err  <= 1'b0;
      done_cnt <= '0;
    end else begin
      if (pop) begin
        {alu_oc, alu_a, alu_b} <= head;
      end
      if (load_out) begin
        out_oc <= alu_oc;
        if (div_by_zero(alu_oc, alu_b)) begin
          out_f   <= '0;
          out_err <= 1'b1;
        end else begin
          out_f   <= alu_f;
          out_err <= 1'b0;
        end
      end
      if (done_inc) done_cnt <= done_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq: directed scenarios plus random traffic against a queue model.
module tb_alu_cmd_seq;

  typedef struct {
    logic [15:0] f;
    logic [2:0]  oc;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_oc;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  alu_oc;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_f;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_f;
  logic [2:0]  out_oc;
  logic        out_err;
  logic [15:0] done_cnt;

  int   checks;
  int   errors;
  int   exp_done;
  exp_t exp_q[$];

  alu_cmd_seq #(
    .DATA_WIDTH (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_oc     (in_oc),
    .in_a      (in_a),
    .in_b      (in_b),
    .alu_oc    (alu_oc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_f     (alu_f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_f     (out_f),
    .out_oc    (out_oc),
    .out_err   (out_err),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU; divide-by-zero yields junk the sequencer must discard.
  always_comb begin
    alu_f = 16'h0000;
    case (alu_oc)
      3'd0: alu_f = alu_a + alu_b;
      3'd1: alu_f = alu_a - alu_b;
      3'd2: alu_f = alu_a * alu_b;
      3'd3: alu_f = (alu_b == 16'h0000) ? 16'hBEEF : alu_a / alu_b;
      3'd4: alu_f = ~alu_a;
      3'd5: alu_f = alu_a ^ alu_b;
      3'd6: alu_f = alu_a | alu_b;
      default: alu_f = alu_a & alu_b;
    endcase
  end

  function automatic exp_t ref_of(input logic [2:0] oc, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.oc  = oc;
    e.err = 1'b0;
    e.f   = 16'h0000;
    case (oc)
      3'd0: e.f = a + b;
      3'd1: e.f = a - b;
      3'd2: e.f = a * b;
      3'd3: begin
        if (b == 16'h0000) e.err = 1'b1;
        else               e.f   = a / b;
      end
      3'd4: e.f = ~a;
      3'd5: e.f = a ^ b;
      3'd6: e.f = a | b;
      default: e.f = a & b;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record what the edge will do, let it happen, score any completed handshake.
  task automatic tick();
    logic        acc;
    logic        hs;
    logic        hold;
    logic [15:0] f_prev;
    logic [2:0]  oc_prev;
    logic        err_prev;
    exp_t        e;
    acc      = in_valid && in_ready && !rst;
    hs       = out_valid && out_ready && !rst;
    hold     = out_valid && !out_ready && !rst;
    f_prev   = out_f;
    oc_prev  = out_oc;
    err_prev = out_err;
    @(posedge clk);
    if (acc) exp_q.push_back(ref_of(in_oc, in_a, in_b));
    if (hs) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result_f", f_prev, e.f);
        check("result_oc", oc_prev, e.oc);
        check("result_err", err_prev, e.err);
        exp_done++;
      end
    end
    @(negedge clk);
    check("done_cnt", done_cnt, exp_done[15:0]);
    if (hold) begin
      check("hold_valid", out_valid, 1);
      check("hold_f", out_f, f_prev);
      check("hold_oc", out_oc, oc_prev);
      check("hold_err", out_err, err_prev);
    end
  endtask

  task automatic push_cmd(input logic [2:0] oc, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    in_oc    = oc;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("push_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] r;
    checks    = 0;
    errors    = 0;
    exp_done  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_oc     = 3'd0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_f", out_f, 0);
    check("rst_out_err", out_err, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_done_cnt", done_cnt, 0);

    // Single ADD: latency of two edges from acceptance to out_valid.
    out_ready = 1'b1;
    in_oc = 3'd0; in_a = 16'd5; in_b = 16'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("lat_t0_valid", out_valid, 0);
    tick();
    check("lat_t1_valid", out_valid, 0);
    tick();
    check("lat_t2_valid", out_valid, 1);
    check("lat_t2_f", out_f, 16'd12);
    check("lat_t2_err", out_err, 0);
    tick();
    check("add_done_cnt", done_cnt, 1);

    // Divide by zero, then a legal divide.
    push_cmd(3'd3, 16'd9, 16'd0);
    push_cmd(3'd3, 16'd9, 16'd3);
    drain();

    // Result hold with backpressure, then fill the FIFO behind it.
    out_ready = 1'b0;
    push_cmd(3'd1, 16'd10, 16'd3);
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    check("hold_seen_valid", out_valid, 1);
    for (int n = 0; n < 10; n++) tick();
    check("hold10_f", out_f, 16'd7);
    check("hold10_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      in_oc = 3'd0; in_a = 16'(i * 100); in_b = 16'(i + 1); in_valid = 1'b1;
      check("bp_in_ready", in_ready, (i < 4) ? 1 : 0);
      tick();
    end
    in_valid = 1'b0;
    check("bp_full", in_ready, 0);
    drain();
    check("bp_ready_after", in_ready, 1);

    // Reset while a command is in EXEC with one more still queued.
    out_ready = 1'b1;
    in_oc = 3'd0; in_a = 16'd1; in_b = 16'd2; in_valid = 1'b1;
    tick();
    in_oc = 3'd6; in_a = 16'h00F0; in_b = 16'h000F;
    tick();
    in_oc = 3'd5; in_a = 16'h1111; in_b = 16'h2222;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_f", out_f, 0);
    check("mid_rst_oc", out_oc, 0);
    check("mid_rst_err", out_err, 0);
    check("mid_rst_alu_oc", alu_oc, 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    check("mid_rst_done", done_cnt, 0);
    exp_q.delete();
    exp_done = 0;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      check("post_rst_no_valid", out_valid, 0);
      check("post_rst_ready", in_ready, 1);
    end
    push_cmd(3'd7, 16'hF0F0, 16'h0FF0);
    drain();

    // Six back-to-back commands wrap the FIFO pointers.
    push_cmd(3'd2, 16'd3, 16'd4);
    push_cmd(3'd4, 16'h0000, 16'h0000);
    push_cmd(3'd5, 16'hF0F0, 16'h0FF0);
    push_cmd(3'd6, 16'h1234, 16'h00FF);
    push_cmd(3'd7, 16'hF0F0, 16'h0FF0);
    push_cmd(3'd0, 16'hFFFF, 16'h0001);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 120; i++) begin
      r = $urandom;
      in_valid  = r[0];
      in_oc     = r[3:1];
      out_ready = (r[5:4] != 2'b00);
      r = $urandom;
      in_a = r[15:0];
      in_b = (r[31:30] == 2'b00) ? 16'h0000 : r[29:14];
      tick();
    end
    in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
